// File: rtl/division_punto_fijo_pkg.sv
// Shared fixed-point definitions: default Q format, word width, symmetric saturation limits and the divider state enum.
package division_punto_fijo_pkg;

    localparam int MAGNITUD = 8;
    localparam int DECIMAL  = 16;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        AJUSTE,
        FIN
    } estado_t;

    function automatic int ancho_palabra(input int magnitud, input int decimal);
        return magnitud + decimal + 1;
    endfunction

    function automatic logic [63:0] maximo(input int n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

    // Symmetric range: the negative limit is -(2^(n-1)-1), never -2^(n-1).
    function automatic logic [63:0] minimo(input int n);
        return ~maximo(n) + 64'd1;
    endfunction

endpackage

// File: rtl/paso_division.sv
// One restoring-division step: shift the next dividend bit into the remainder and subtract the divisor if it fits.
module paso_division #(
    parameter int W = 24
) (
    input  logic [W-1:0] resto,
    input  logic         bit_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] resto_sig,
    output logic         q_bit
);

    logic [W:0]   desplazado;
    logic [W-1:0] diferencia;

    always_comb begin
        desplazado = {resto, bit_in};
        q_bit      = (desplazado >= {1'b0, divisor});
        diferencia = desplazado[W-1:0] - divisor;
        resto_sig  = q_bit ? diferencia : desplazado[W-1:0];
    end

endmodule

// File: rtl/division_punto_fijo.sv
// Signed fixed-point divider, one quotient bit per cycle with symmetric saturation.
// Define DIV_REDONDEO_EN to round half away from zero (one extra cycle) instead of truncating.
module division_punto_fijo
    import division_punto_fijo_pkg::*;
#(
    parameter int Magnitud = MAGNITUD,
    parameter int Decimal  = DECIMAL
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [Magnitud+Decimal:0]   A,
    input  logic [Magnitud+Decimal:0]   B,
    output logic [Magnitud+Decimal:0]   div,
    output logic                        busy,
    output logic                        done,
    output logic                        div_cero
);

    localparam int N = ancho_palabra(Magnitud, Decimal);
`ifdef DIV_REDONDEO_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int ITER = N - 1 + Decimal + EXTRA;
    localparam int CW   = $clog2(ITER);
    localparam logic [N-1:0] MAX_W = N'(maximo(N));
    localparam logic [N-1:0] MIN_W = N'(minimo(N));

    estado_t         estado;
    estado_t         estado_sig;
    logic [CW-1:0]   cnt;
    logic [ITER-1:0] cociente;
    logic [N-2:0]    resto;
    logic [N-2:0]    resto_sig;
    logic [N-2:0]    divisor;
    logic [N-2:0]    mag_a;
    logic [N-2:0]    mag_b;
    logic            q_bit;
    logic            signo;
    logic            a_cero;
    logic            b_cero;
    logic [ITER-1:0] q_mag;
    logic [N-1:0]    q_sat;
    logic [N-1:0]    resultado;
    logic [N-1:0]    resultado_sig;

    // The most negative word has no positive counterpart, so its magnitude clamps to the maximum.
    function automatic logic [N-2:0] magnitud(input logic [N-1:0] x);
        logic [N-1:0] neg;
        neg = ~x + 1'b1;
        if (!x[N-1])
            return x[N-2:0];
        else if (x[N-2:0] == '0)
            return '1;
        else
            return neg[N-2:0];
    endfunction

    always_comb begin
        mag_a = magnitud(A);
        mag_b = magnitud(B);
    end

    paso_division #(
        .W (N - 1)
    ) u_paso (
        .resto     (resto),
        .bit_in    (cociente[ITER-1]),
        .divisor   (divisor),
        .resto_sig (resto_sig),
        .q_bit     (q_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            estado <= IDLE;
        else
            estado <= estado_sig;
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            IDLE:    if (start) estado_sig = CALC;
            CALC:    if (cnt == '0) estado_sig = AJUSTE;
            AJUSTE:  estado_sig = FIN;
            FIN:     estado_sig = IDLE;
            default: estado_sig = IDLE;
        endcase
    end

    always_comb begin
        q_mag         = '0;
        q_sat         = '0;
        resultado_sig = '0;
`ifdef DIV_REDONDEO_EN
        q_mag = {1'b0, cociente[ITER-1:1]} + ITER'(cociente[0]);
`else
        q_mag = cociente;
`endif
        q_sat = (q_mag > ITER'(MAX_W)) ? MAX_W : q_mag[N-1:0];
        if (a_cero)
            resultado_sig = '0;
        else if (b_cero)
            resultado_sig = signo ? MIN_W : MAX_W;
        else
            resultado_sig = signo ? (~q_sat + 1'b1) : q_sat;
    end

    // The dividend shifts out of the top of cociente while quotient bits fill it from the bottom.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            cociente  <= '0;
            resto     <= '0;
            divisor   <= '0;
            signo     <= 1'b0;
            a_cero    <= 1'b0;
            b_cero    <= 1'b0;
            resultado <= '0;
            div       <= '0;
            div_cero  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (estado)
                IDLE: begin
                    if (start) begin
                        divisor  <= mag_b;
                        cociente <= {mag_a, {(Decimal + EXTRA){1'b0}}};
                        resto    <= '0;
                        signo    <= A[N-1] ^ B[N-1];
                        a_cero   <= (mag_a == '0);
                        b_cero   <= (mag_b == '0);
                        cnt      <= CW'(ITER - 1);
                        busy     <= 1'b1;
                    end
                end
                CALC: begin
                    cociente <= {cociente[ITER-2:0], q_bit};
                    resto    <= resto_sig;
                    cnt      <= cnt - CW'(1);
                end
                AJUSTE: resultado <= resultado_sig;
                FIN: begin
                    div      <= resultado;
                    div_cero <= b_cero;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_division_punto_fijo.sv
// Directed bench for division_punto_fijo: expected results are queued at start and compared when done pulses.
module tb_division_punto_fijo;

    localparam int N   = 25;
    localparam int DEC = 16;
`ifdef DIV_REDONDEO_EN
    localparam int LAT = 43;
`else
    localparam int LAT = 42;
`endif
    localparam logic [N-1:0] MAXV = 25'h0FFFFFF;
    localparam logic [N-1:0] MINV = 25'h1000001;

    typedef struct packed {
        logic         cero;
        logic [N-1:0] q;
    } esperado_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] div;
    logic         busy;
    logic         done;
    logic         div_cero;

    int tests = 0;
    int fails = 0;
    esperado_t sb[$];

    division_punto_fijo dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .A        (A),
        .B        (B),
        .div      (div),
        .busy     (busy),
        .done     (done),
        .div_cero (div_cero)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference built from integer arithmetic on the operand values.
    function automatic esperado_t model(input logic [N-1:0] a, input logic [N-1:0] b);
        esperado_t   e;
        longint      ma, mb, q;
        logic        neg;
        logic [63:0] r;
        ma  = longint'($signed(a));
        mb  = longint'($signed(b));
        ma  = (ma < 0) ? -ma : ma;
        mb  = (mb < 0) ? -mb : mb;
        if (ma > longint'(MAXV)) ma = longint'(MAXV);
        if (mb > longint'(MAXV)) mb = longint'(MAXV);
        neg = a[N-1] ^ b[N-1];
        if (ma == 0)
            q = 0;
        else if (mb == 0) begin
            q   = longint'(MAXV);
            neg = a[N-1];
        end else begin
`ifdef DIV_REDONDEO_EN
            q = ((ma << (DEC + 1)) / mb + 1) >> 1;
`else
            q = (ma << DEC) / mb;
`endif
            if (q > longint'(MAXV)) q = longint'(MAXV);
        end
        r      = 64'(neg ? -q : q);
        e.q    = r[N-1:0];
        e.cero = (mb == 0);
        return e;
    endfunction

    task automatic apply_stimulus(input logic [N-1:0] a, input logic [N-1:0] b, input esperado_t e);
        A     = a;
        B     = b;
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        check_output("busy_rise", busy, 1);
        check_output("done_low", done, 0);
    endtask

    task automatic wait_done(input string tag, input bit molestar, input bit encadenar);
        int        cycles;
        esperado_t e;
        cycles = 0;
        while (done !== 1'b1 && cycles < LAT + 10) begin
            @(posedge clk);
            #1;
            cycles++;
            if (molestar && cycles == 5) begin
                start = 1'b1;
                A     = ~A;
                B     = B + 25'h0010000;
            end
            if (molestar && cycles == 7) start = 1'b0;
        end
        e = sb.pop_front();
        check_output({tag, "_latency"}, cycles, LAT);
        check_output({tag, "_busy_low"}, busy, 0);
        check_output({tag, "_div"}, div, e.q);
        check_output({tag, "_div_cero"}, div_cero, e.cero);
        if (!encadenar) begin
            @(posedge clk);
            #1;
            check_output({tag, "_done_pulse"}, done, 0);
            check_output({tag, "_div_hold"}, div, e.q);
        end
    endtask

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        bit           seen_done;

        reset = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        #2;
        check_output("reset_div", div, 0);
        check_output("reset_busy", busy, 0);
        check_output("reset_done", done, 0);
        check_output("reset_div_cero", div_cero, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        apply_stimulus(25'h0060000, 25'h0020000, '{cero: 1'b0, q: 25'h0030000});
        wait_done("seis_entre_dos", 1'b0, 1'b0);

        apply_stimulus(25'h1FF0000, 25'h0040000, '{cero: 1'b0, q: 25'h1FFC000});
        wait_done("menos_cuarto", 1'b1, 1'b0);

        apply_stimulus(25'h0C80000, 25'h0008000, '{cero: 1'b0, q: MAXV});
        wait_done("sat_pos", 1'b0, 1'b0);

        apply_stimulus(25'h1380000, 25'h0008000, '{cero: 1'b0, q: MINV});
        wait_done("sat_neg", 1'b0, 1'b0);

        apply_stimulus(25'h1000000, 25'h0010000, '{cero: 1'b0, q: MINV});
        wait_done("min_clamp", 1'b0, 1'b0);

        apply_stimulus(25'h0010000, 25'h0000000, '{cero: 1'b1, q: MAXV});
        wait_done("uno_entre_cero", 1'b0, 1'b0);

        // Abort a division at cycle 20 after an ignored start at cycle 10.
        A     = 25'h0050000;
        B     = 25'h0010000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1;
        A     = 25'h0070000;
        B     = 25'h0000000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_output("abort_div", div, 0);
        check_output("abort_div_cero", div_cero, 0);
        check_output("abort_busy", busy, 0);
        check_output("abort_done", done, 0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < LAT + 5; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
        end
        check_output("abort_no_done", seen_done, 0);

        apply_stimulus(25'h0000000, 25'h0000000, '{cero: 1'b1, q: 25'h0000000});
        wait_done("cero_entre_cero", 1'b0, 1'b0);

`ifdef DIV_REDONDEO_EN
        apply_stimulus(25'h0020000, 25'h0030000, '{cero: 1'b0, q: 25'h000AAAB});
`else
        apply_stimulus(25'h0020000, 25'h0030000, '{cero: 1'b0, q: 25'h000AAAA});
`endif
        wait_done("dos_tercios", 1'b0, 1'b0);

        // Back-to-back requests: each start is raised during the previous done cycle.
        for (int i = 0; i < 3; i++) begin
            ra = 25'($urandom);
            rb = 25'($urandom) >> (4 * i + 2);
            if (rb == '0) rb = 25'h0000001;
            apply_stimulus(ra, rb, model(ra, rb));
            wait_done("aleatorio", 1'b0, i < 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/division_punto_fijo.md
DIVISION_PUNTO_FIJO -- requirements
Module: division_punto_fijo

Interface
REQ-001 SHALL have parameter Magnitud, default 8, integer bits of the operand format.
REQ-002 SHALL have parameter Decimal, default 16, fractional bits; word width N = Magnitud+Decimal+1 (25 by default).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request; sampled only while busy=0.
REQ-006 SHALL have port A  input  N  signed two's-complement dividend, same Q format as B.
REQ-007 SHALL have port B  input  N  signed divisor.
REQ-008 SHALL have port div  output  N  signed registered quotient A/B.
REQ-009 SHALL have port busy  output  1  high while a division is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when div is updated.
REQ-011 SHALL have port div_cero  output  1  registered flag, B was zero in the last division; valid with done.

Function
REQ-012 SHALL use states IDLE, CALC, AJUSTE, FIN: IDLE->CALC on start; CALC->AJUSTE after the last iteration; AJUSTE->FIN; FIN->IDLE unconditionally.
REQ-013 SHALL, on start in IDLE, register A, B, result sign (A[N-1] XOR B[N-1]) and magnitudes |A|, |B|; busy rises the next cycle.
REQ-014 SHALL clamp magnitude of -2^(N-1) to 2^(N-1)-1.
REQ-015 SHALL compute Q = (|A| << Decimal) / |B| by restoring division, one quotient bit per cycle, N-1+Decimal iterations (40 by default).
REQ-016 SHALL truncate toward zero when DIV_REDONDEO_EN is not defined.
REQ-017 SHALL saturate in AJUSTE: Q > 2^(N-1)-1 gives maximo = 2^(N-1)-1 for positive sign and minimo = -(2^(N-1)-1) for negative sign (symmetric range).
REQ-018 SHALL, if |A|=0, yield div=0 regardless of B; div_cero=1 if B is also zero.
REQ-019 SHALL, if B=0 and A!=0, yield maximo when A is positive and minimo when A is negative, with div_cero=1, and still take the full latency.
REQ-020 SHALL otherwise apply the sign to the saturated magnitude; never produce a saturated value of -2^(N-1).
REQ-021 SHALL update div and div_cero and assert done for exactly one cycle in FIN; busy deasserts the same cycle.
REQ-022 SHALL assert done 42 cycles after the edge sampling start (N-1+Decimal+2 in general).
REQ-023 SHALL ignore start while busy=1; operand changes during busy SHALL NOT affect the result.
REQ-024 SHALL hold div and div_cero between completions.
REQ-025 SHALL accept start asserted in the cycle done is high, taking it from IDLE on the following edge with no lost request.

Reset
REQ-026 SHALL, on reset, force state IDLE, div=0, busy=0, done=0, div_cero=0 and all internal registers to 0, asynchronously, aborting any division in progress.
REQ-027 SHALL require a new start after reset release; an aborted division SHALL NOT produce done.

Configuration
REQ-028 SHALL, with macro DIV_REDONDEO_EN defined, compute one extra quotient bit, round the magnitude half away from zero, then saturate; latency becomes 43 cycles.
REQ-029 SHALL, without DIV_REDONDEO_EN, truncate with 42-cycle latency and contain no rounding logic.

Structure
REQ-030 SHALL take Magnitud, Decimal, N, maximo, minimo and the state enum from a shared fixed-point package, also used by the multiplier.
REQ-031 SHALL use one combinational sub-module, paso_division, that performs one restoring subtract/shift step, instantiated once.

Verification
REQ-032 SHALL cover: A=0x060000 (6.0), B=0x020000 (2.0), start -> done at +42, div=0x030000, div_cero=0.
REQ-033 SHALL cover: A=-0x010000, B=0x040000 -> div=-0x004000 (-0.25).
REQ-034 SHALL cover: A=0x0C80000 (200.0), B=0x008000 (0.5) -> div=0x0FFFFFF (maximo); negating A -> -0x0FFFFFF.
REQ-035 SHALL cover: A=0x010000, B=0 -> div=0x0FFFFFF, div_cero=1; A=0, B=0 -> div=0, div_cero=1.
REQ-036 SHALL cover: A=0x020000, B=0x030000 -> div=0x00AAAA without DIV_REDONDEO_EN, 0x00AAAB with it at +43.
REQ-037 SHALL cover: reset asserted at cycle 20 of a division, then start issued during busy -> outputs 0 at once, no done, start ignored, next start completes normally.
